// File: rtl/axil_regs_pkg.sv
// Shared constants, FSM state types and the address decode helper for the
// AXI4-Lite statistics/control register block.
package axil_regs_pkg;

    localparam logic [1:0] AXI_RESP_OK     = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

    typedef enum logic {
        WR_IDLE,
        WR_RESP
    } wr_state_t;

    typedef enum logic {
        RD_IDLE,
        RD_DATA
    } rd_state_t;

    // Byte address to word index; callers zero-extend their address to 64 bits.
    function automatic logic [63:0] addr_to_idx(input logic [63:0] addr,
                                                input int unsigned lsb);
        return addr >> lsb;
    endfunction

endpackage

// File: rtl/axil_sat_counter.sv
// Saturating event counter with synchronous clear and an optional
// clear-on-read strobe that still keeps the increment of the read cycle.
module axil_sat_counter #(
    parameter int WIDTH       = 32,
    parameter bit CLR_ON_READ = 1'b0
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             inc,
    input  logic             clr,
    input  logic             rd_clr,
    output logic [WIDTH-1:0] count
);

    logic rd_clr_eff;

    assign rd_clr_eff = CLR_ON_READ ? rd_clr : 1'b0;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (rd_clr_eff) begin
            // the value just read is gone; an event in the same cycle survives
            count <= WIDTH'(inc);
        end else if (inc && (count != '1)) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/axi4_lite_stats_regs.sv
// AXI4-Lite slave with NUM_RW control registers and NUM_CNT saturating event counters.
// Optional build macro: AXIL_STATS_CLR_ON_READ_EN (counter reads clear the counter).
module axi4_lite_stats_regs
    import axil_regs_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_RW     = 8,
    parameter int NUM_CNT    = 8,
    parameter int CNT_WIDTH  = 32,
    parameter logic [NUM_RW*DATA_WIDTH-1:0] RW_RESET = '0
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic [ADDR_WIDTH-1:0]        AWADDR,
    input  logic                         AWVALID,
    output logic                         AWREADY,
    input  logic [DATA_WIDTH-1:0]        WDATA,
    input  logic [DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                         WVALID,
    output logic                         WREADY,
    output logic [1:0]                   BRESP,
    output logic                         BVALID,
    input  logic                         BREADY,
    input  logic [ADDR_WIDTH-1:0]        ARADDR,
    input  logic                         ARVALID,
    output logic                         ARREADY,
    output logic [DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                   RRESP,
    output logic                         RVALID,
    input  logic                         RREADY,
    input  logic [NUM_CNT-1:0]           cnt_inc,
    input  logic                         cnt_clr,
    output logic [NUM_RW*DATA_WIDTH-1:0] ctrl_out
);

    localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
    localparam int          STRB_W   = DATA_WIDTH / 8;
`ifdef AXIL_STATS_CLR_ON_READ_EN
    localparam bit CLR_ON_READ = 1'b1;
`else
    localparam bit CLR_ON_READ = 1'b0;
`endif

    wr_state_t             wr_state;
    rd_state_t             rd_state;
    logic [ADDR_WIDTH-1:0] awaddr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [STRB_W-1:0]     wstrb_q;
    logic                  aw_held;
    logic                  w_held;
    logic [DATA_WIDTH-1:0] rw_q    [NUM_RW];
    logic [CNT_WIDTH-1:0]  cnt_val [NUM_CNT];
    logic [NUM_CNT-1:0]    cnt_rd_clr;
    logic [63:0]           wr_idx;
    logic [63:0]           rd_idx;
    logic                  wr_is_rw;
    logic                  ar_hs;
    logic [DATA_WIDTH-1:0] rd_mux;
    logic [1:0]            rd_resp;

    assign wr_idx   = addr_to_idx(64'(awaddr_q), ADDR_LSB);
    assign rd_idx   = addr_to_idx(64'(ARADDR), ADDR_LSB);
    assign wr_is_rw = wr_idx < 64'(NUM_RW);
    assign ar_hs    = ARVALID && ARREADY;

    // Write side: AW and W are parked independently; the write commits one edge after both are held.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            wr_state <= WR_IDLE;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
            BVALID   <= 1'b0;
            BRESP    <= AXI_RESP_OK;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            awaddr_q <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            for (int i = 0; i < NUM_RW; i++) begin
                rw_q[i] <= RW_RESET[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end else begin
            case (wr_state)
                WR_IDLE: begin
                    if (AWVALID && AWREADY) begin
                        awaddr_q <= AWADDR;
                        aw_held  <= 1'b1;
                        AWREADY  <= 1'b0;
                    end
                    if (WVALID && WREADY) begin
                        wdata_q <= WDATA;
                        wstrb_q <= WSTRB;
                        w_held  <= 1'b1;
                        WREADY  <= 1'b0;
                    end
                    if (aw_held && w_held) begin
                        for (int i = 0; i < NUM_RW; i++) begin
                            if (wr_idx == 64'(i)) begin
                                for (int b = 0; b < STRB_W; b++) begin
                                    if (wstrb_q[b]) rw_q[i][b*8 +: 8] <= wdata_q[b*8 +: 8];
                                end
                            end
                        end
                        BVALID   <= 1'b1;
                        BRESP    <= wr_is_rw ? AXI_RESP_OK : AXI_RESP_SLVERR;
                        wr_state <= WR_RESP;
                    end
                end
                WR_RESP: begin
                    if (BREADY) begin
                        BVALID   <= 1'b0;
                        AWREADY  <= 1'b1;
                        WREADY   <= 1'b1;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        wr_state <= WR_IDLE;
                    end
                end
                default: wr_state <= WR_IDLE;
            endcase
        end
    end

    always_comb begin
        rd_mux  = '0;
        rd_resp = AXI_RESP_SLVERR;
        for (int i = 0; i < NUM_RW; i++) begin
            if (rd_idx == 64'(i)) begin
                rd_mux  = rw_q[i];
                rd_resp = AXI_RESP_OK;
            end
        end
        for (int i = 0; i < NUM_CNT; i++) begin
            if (rd_idx == 64'(NUM_RW + i)) begin
                rd_mux  = DATA_WIDTH'(cnt_val[i]);
                rd_resp = AXI_RESP_OK;
            end
        end
    end

    always_comb begin
        cnt_rd_clr = '0;
        for (int i = 0; i < NUM_CNT; i++) begin
            cnt_rd_clr[i] = ar_hs && (rd_idx == 64'(NUM_RW + i));
        end
    end

    // Read data is captured at the AR handshake and held until RREADY.
    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            rd_state <= RD_IDLE;
            ARREADY  <= 1'b1;
            RVALID   <= 1'b0;
            RDATA    <= '0;
            RRESP    <= AXI_RESP_OK;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (ar_hs) begin
                        RDATA    <= rd_mux;
                        RRESP    <= rd_resp;
                        RVALID   <= 1'b1;
                        ARREADY  <= 1'b0;
                        rd_state <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (RREADY) begin
                        RVALID   <= 1'b0;
                        ARREADY  <= 1'b1;
                        rd_state <= RD_IDLE;
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_RW; gi++) begin : g_ctrl
        assign ctrl_out[gi*DATA_WIDTH +: DATA_WIDTH] = rw_q[gi];
    end

    for (genvar gc = 0; gc < NUM_CNT; gc++) begin : g_cnt
        axil_sat_counter #(
            .WIDTH       (CNT_WIDTH),
            .CLR_ON_READ (CLR_ON_READ)
        ) u_cnt (
            .ACLK    (ACLK),
            .ARESETN (ARESETN),
            .inc     (cnt_inc[gc]),
            .clr     (cnt_clr),
            .rd_clr  (cnt_rd_clr[gc]),
            .count   (cnt_val[gc])
        );
    end

endmodule

// File: tb/tb_axi4_lite_stats_regs.sv
// Directed bench for axi4_lite_stats_regs (4-bit counters so saturation is reachable);
// expectations follow AXIL_STATS_CLR_ON_READ_EN when it is defined.
module tb_axi4_lite_stats_regs;

    logic         ACLK;
    logic         ARESETN;
    logic [31:0]  AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [31:0]  ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [7:0]   cnt_inc;
    logic         cnt_clr;
    logic [255:0] ctrl_out;

    localparam logic [255:0] RST_VALS = {32'hDEAD_0007, 192'h0, 32'h0000_7700};

    int          vec;
    int          miscompares;
    logic [31:0] exp_rw [8];

    axi4_lite_stats_regs #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .NUM_RW     (8),
        .NUM_CNT    (8),
        .CNT_WIDTH  (4),
        .RW_RESET   (RST_VALS)
    ) dut (
        .ACLK     (ACLK),
        .ARESETN  (ARESETN),
        .AWADDR   (AWADDR),
        .AWVALID  (AWVALID),
        .AWREADY  (AWREADY),
        .WDATA    (WDATA),
        .WSTRB    (WSTRB),
        .WVALID   (WVALID),
        .WREADY   (WREADY),
        .BRESP    (BRESP),
        .BVALID   (BVALID),
        .BREADY   (BREADY),
        .ARADDR   (ARADDR),
        .ARVALID  (ARVALID),
        .ARREADY  (ARREADY),
        .RDATA    (RDATA),
        .RRESP    (RRESP),
        .RVALID   (RVALID),
        .RREADY   (RREADY),
        .cnt_inc  (cnt_inc),
        .cnt_clr  (cnt_clr),
        .ctrl_out (ctrl_out)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [255:0] pack_exp();
        logic [255:0] p;
        p = '0;
        for (int i = 0; i < 8; i++) p[i*32 +: 32] = exp_rw[i];
        return p;
    endfunction

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        logic aw_done, w_done, aw_hs, w_hs;
        int   n;
        aw_done = 1'b0;
        w_done  = 1'b0;
        n       = 0;
        AWADDR  = addr;
        AWVALID = 1'b1;
        WDATA   = data;
        WSTRB   = strb;
        WVALID  = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = AWVALID && AWREADY;
            w_hs  = WVALID && WREADY;
            tick();
            n++;
            if (aw_hs) begin aw_done = 1'b1; AWVALID = 1'b0; end
            if (w_hs)  begin w_done  = 1'b1; WVALID  = 1'b0; end
        end
        vec++;
        if (!(aw_done && w_done)) begin
            miscompares++;
            $display("FAIL wr_handshake_timeout addr=%h aw=%0b w=%0b required both 1", addr, aw_done, w_done);
            AWVALID = 1'b0;
            WVALID  = 1'b0;
        end
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 50) begin tick(); n++; end
        vec++;
        if (BVALID !== 1'b1) begin
            miscompares++;
            $display("FAIL bvalid_timeout addr=%h got BVALID=%b required 1", addr, BVALID);
        end
        resp = BRESP;
        tick();
        BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp, output int lat);
        int n;
        ARADDR  = addr;
        ARVALID = 1'b1;
        n = 0;
        while (!ARREADY && n < 50) begin tick(); n++; end
        vec++;
        if (ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL arready_timeout addr=%h got %b required 1", addr, ARREADY);
        end
        tick();
        ARVALID = 1'b0;
        RREADY  = 1'b1;
        lat = 1;
        while (!RVALID && lat < 50) begin tick(); lat++; end
        data = RDATA;
        resp = RRESP;
        tick();
        RREADY = 1'b0;
    endtask

    task automatic pulse_inc(input logic [7:0] mask, input int cycles);
        cnt_inc = mask;
        repeat (cycles) tick();
        cnt_inc = '0;
    endtask

    task automatic pulse_clr();
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        ARESETN = 1'b0;
        AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b0;
        ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0; cnt_inc = '0; cnt_clr = 1'b0;
        for (int i = 0; i < 8; i++) exp_rw[i] = 32'h0;
        exp_rw[0] = 32'h0000_7700;
        exp_rw[7] = 32'hDEAD_0007;
        repeat (3) tick();
        ARESETN = 1'b1;
        vec++;
        if ({AWREADY, WREADY, ARREADY} !== 3'b111) begin
            miscompares++;
            $display("FAIL reset_readies got %b required 111", {AWREADY, WREADY, ARREADY});
        end
        vec++;
        if ({BVALID, RVALID} !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_valids got %b required 00", {BVALID, RVALID});
        end
        vec++;
        if ({BRESP, RRESP, RDATA} !== 36'h0) begin
            miscompares++;
            $display("FAIL reset_resp_rdata got %h required 0", {BRESP, RRESP, RDATA});
        end
        vec++;
        if (ctrl_out !== pack_exp()) begin
            miscompares++;
            $display("FAIL reset_ctrl_out got %h required %h", ctrl_out, pack_exp());
        end
        axi_read(32'h0, d, r, lat);
        vec++;
        if (lat !== 1) begin
            miscompares++;
            $display("FAIL read_latency got %0d required 1", lat);
        end
        vec++;
        if (d !== 32'h0000_7700 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL read_idx0 got %h/%b required 00007700/00", d, r);
        end
    endtask

    task automatic test_w_before_aw();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat, n;
        WDATA = 32'hA5A5_1234; WSTRB = 4'b0011; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        vec++;
        if ({WREADY, AWREADY, BVALID} !== 3'b010) begin
            miscompares++;
            $display("FAIL w_only_ready got W/AW/B=%b required 010", {WREADY, AWREADY, BVALID});
        end
        repeat (2) tick();
        vec++;
        if (BVALID !== 1'b0) begin
            miscompares++;
            $display("FAIL early_bvalid got %b required 0", BVALID);
        end
        AWADDR = 32'h4; AWVALID = 1'b1;
        tick();
        AWVALID = 1'b0;
        vec++;
        if ({AWREADY, BVALID} !== 2'b00) begin
            miscompares++;
            $display("FAIL aw_taken got AW/B=%b required 00", {AWREADY, BVALID});
        end
        BREADY = 1'b1;
        n = 0;
        while (!BVALID && n < 20) begin tick(); n++; end
        vec++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL w_first_bresp got valid=%b resp=%b required 1/00", BVALID, BRESP);
        end
        tick();
        BREADY = 1'b0;
        vec++;
        if ({BVALID, AWREADY, WREADY} !== 3'b011) begin
            miscompares++;
            $display("FAIL b_single got B/AW/W=%b required 011", {BVALID, AWREADY, WREADY});
        end
        exp_rw[1] = 32'h0000_1234;
        axi_read(32'h4, d, r, lat);
        vec++;
        if (d !== 32'h0000_1234 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL strobe_read_idx1 got %h/%b required 00001234/00", d, r);
        end
    endtask

    task automatic test_strobes();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        axi_write(32'hC, 32'hFFFF_FFFF, 4'b1111, r);
        vec++;
        if (r !== 2'b00) begin miscompares++; $display("FAIL full_write_bresp got %b required 00", r); end
        axi_write(32'hC, 32'h1234_5678, 4'b1000, r);
        axi_write(32'hC, 32'hAABB_CCDD, 4'b0100, r);
        exp_rw[3] = 32'h12BB_FFFF;
        axi_read(32'hC, d, r, lat);
        vec++;
        if (d !== 32'h12BB_FFFF) begin
            miscompares++;
            $display("FAIL byte_merge_idx3 got %h required 12bbffff", d);
        end
        vec++;
        if (ctrl_out !== pack_exp()) begin
            miscompares++;
            $display("FAIL ctrl_out_after_strobes got %h required %h", ctrl_out, pack_exp());
        end
    endtask

    task automatic test_counter_hold();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        pulse_clr();
        pulse_inc(8'h04, 5);
        ARADDR = 32'h28; ARVALID = 1'b1;
        tick();
        ARVALID = 1'b0;
        vec++;
        if (RVALID !== 1'b1 || RDATA !== 32'd5 || RRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL cnt2_read got valid=%b data=%h resp=%b required 1/5/00", RVALID, RDATA, RRESP);
        end
        cnt_inc = 8'h04;
        for (int i = 0; i < 4; i++) begin
            tick();
            vec++;
            if (RVALID !== 1'b1 || RDATA !== 32'd5 || ARREADY !== 1'b0) begin
                miscompares++;
                $display("FAIL r_hold cyc%0d got valid=%b data=%h arready=%b required 1/5/0", i, RVALID, RDATA, ARREADY);
            end
        end
        cnt_inc = '0;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        vec++;
        if ({RVALID, ARREADY} !== 2'b01) begin
            miscompares++;
            $display("FAIL r_release got RV/AR=%b required 01", {RVALID, ARREADY});
        end
        axi_read(32'h28, d, r, lat);
        vec++;
`ifdef AXIL_STATS_CLR_ON_READ_EN
        if (d !== 32'd4) begin miscompares++; $display("FAIL cnt2_reread got %0d required 4", d); end
`else
        if (d !== 32'd9) begin miscompares++; $display("FAIL cnt2_reread got %0d required 9", d); end
`endif
    endtask

    task automatic test_saturation();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        pulse_clr();
        pulse_inc(8'h01, 20);
        axi_read(32'h20, d, r, lat);
        vec++;
        if (d !== 32'd15) begin miscompares++; $display("FAIL cnt0_saturate got %0d required 15", d); end
        pulse_inc(8'h01, 3);
        pulse_clr();
        axi_read(32'h20, d, r, lat);
        vec++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL cnt0_clear got %0d required 0", d); end
        pulse_inc(8'h01, 3);
        cnt_inc = 8'h01; cnt_clr = 1'b1;
        tick();
        cnt_inc = '0; cnt_clr = 1'b0;
        axi_read(32'h20, d, r, lat);
        vec++;
        if (d !== 32'd0) begin miscompares++; $display("FAIL clr_priority got %0d required 0", d); end
    endtask

    task automatic test_slverr();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        pulse_clr();
        pulse_inc(8'h02, 3);
        axi_write(32'h24, 32'hFFFF_FFFF, 4'b1111, r);
        vec++;
        if (r !== 2'b10) begin miscompares++; $display("FAIL cnt_write_bresp got %b required 10", r); end
        axi_read(32'h24, d, r, lat);
        vec++;
        if (d !== 32'd3 || r !== 2'b00) begin
            miscompares++;
            $display("FAIL cnt1_unchanged got %h/%b required 3/00", d, r);
        end
        axi_write(32'h40, 32'h5555_5555, 4'b1111, r);
        vec++;
        if (r !== 2'b10) begin miscompares++; $display("FAIL unmapped_write_bresp got %b required 10", r); end
        vec++;
        if (ctrl_out !== pack_exp()) begin
            miscompares++;
            $display("FAIL ctrl_out_after_slverr got %h required %h", ctrl_out, pack_exp());
        end
        axi_read(32'h40, d, r, lat);
        vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL unmapped_read got %h/%b required 0/10", d, r);
        end
        axi_read(32'h100, d, r, lat);
        vec++;
        if (d !== 32'h0 || r !== 2'b10) begin
            miscompares++;
            $display("FAIL far_unmapped_read got %h/%b required 0/10", d, r);
        end
    endtask

    task automatic test_clr_on_read();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        pulse_clr();
        pulse_inc(8'h10, 7);
        ARADDR = 32'h30; ARVALID = 1'b1; cnt_inc = 8'h10;
        tick();
        ARVALID = 1'b0; cnt_inc = '0; RREADY = 1'b1;
        vec++;
        if (RVALID !== 1'b1 || RDATA !== 32'd7) begin
            miscompares++;
            $display("FAIL cnt4_first_read got valid=%b data=%0d required 1/7", RVALID, RDATA);
        end
        tick();
        RREADY = 1'b0;
        axi_read(32'h30, d, r, lat);
        vec++;
`ifdef AXIL_STATS_CLR_ON_READ_EN
        if (d !== 32'd1) begin miscompares++; $display("FAIL cnt4_second_read got %0d required 1", d); end
`else
        if (d !== 32'd8) begin miscompares++; $display("FAIL cnt4_second_read got %0d required 8", d); end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic [1:0]  r;
        int          lat;
        AWADDR = 32'h8; AWVALID = 1'b1; WDATA = 32'hCAFE_F00D; WSTRB = 4'b1111; WVALID = 1'b1;
        ARADDR = 32'h8; ARVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
        RREADY = 1'b1; BREADY = 1'b1;
        vec++;
        if (RVALID !== 1'b1 || RDATA !== 32'h0) begin
            miscompares++;
            $display("FAIL rw_same_cycle_old got valid=%b data=%h required 1/00000000", RVALID, RDATA);
        end
        tick();
        RREADY = 1'b0;
        vec++;
        if (BVALID !== 1'b1 || BRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL b2b_bresp got valid=%b resp=%b required 1/00", BVALID, BRESP);
        end
        tick();
        BREADY = 1'b0;
        exp_rw[2] = 32'hCAFE_F00D;
        axi_read(32'h8, d, r, lat);
        vec++;
        if (d !== 32'hCAFE_F00D) begin
            miscompares++;
            $display("FAIL b2b_readback got %h required cafef00d", d);
        end
        axi_read(32'h1C, d, r, lat);
        vec++;
        if (d !== 32'hDEAD_0007 || lat !== 1) begin
            miscompares++;
            $display("FAIL idx7_reset_read got %h lat %0d required dead0007 lat 1", d, lat);
        end
        vec++;
        if (ctrl_out !== pack_exp()) begin
            miscompares++;
            $display("FAIL ctrl_out_final got %h required %h", ctrl_out, pack_exp());
        end
    endtask

    initial begin
        vec = 0;
        miscompares = 0;
        test_reset();
        test_w_before_aw();
        test_strobes();
        test_counter_hold();
        test_saturation();
        test_slverr();
        test_clr_on_read();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscompares);
        $finish;
    end

endmodule
